// File: rtl/cordic_sqrt_arbiter_if.sv
// rtl/cordic_sqrt_arbiter_if.sv - client request/response and datapath handshake bundle for cordic_sqrt_arbiter
interface cordic_sqrt_arbiter_if #(
    parameter int WIDTH = 16
) ();
    logic             req0_val;
    logic             req0_rdy;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_val;
    logic             req1_rdy;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             resp0_val;
    logic             resp0_rdy;
    logic             resp1_val;
    logic             resp1_rdy;
    logic [WIDTH-1:0] resp_data;
    logic             resp_err;
    logic             cor_operands_val;
    logic             cor_ready;
    logic [WIDTH-1:0] cor_a;
    logic [WIDTH-1:0] cor_b;
    logic             cor_out_valid;
    logic [WIDTH-1:0] cor_theta;
    logic             busy;

    // Environment side: clients plus the datapath instance
    modport master (
        output req0_val, req0_a, req0_b, req1_val, req1_a, req1_b,
        output resp0_rdy, resp1_rdy, cor_ready, cor_out_valid, cor_theta,
        input  req0_rdy, req1_rdy, resp0_val, resp1_val, resp_data, resp_err,
        input  cor_operands_val, cor_a, cor_b, busy
    );

    // Arbiter side
    modport slave (
        input  req0_val, req0_a, req0_b, req1_val, req1_a, req1_b,
        input  resp0_rdy, resp1_rdy, cor_ready, cor_out_valid, cor_theta,
        output req0_rdy, req1_rdy, resp0_val, resp1_val, resp_data, resp_err,
        output cor_operands_val, cor_a, cor_b, busy
    );
endinterface

// File: rtl/cordic_sqrt_arbiter.sv
// rtl/cordic_sqrt_arbiter.sv - round-robin sharing of one CORDIC sqrt datapath between two clients (optional watchdog: CORDIC_TIMEOUT_EN)
module cordic_sqrt_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cordic_sqrt_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t           state_q;
    logic             rr_ptr_q;
    logic             grant_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] data_q;

    logic             gnt_fire;
    logic             gnt_id_d;
    logic             resp_rdy_sel;

`ifdef CORDIC_TIMEOUT_EN
    localparam int               CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
`endif

    // Grant decision: lone requester wins, contention goes to rr_ptr
    always_comb begin
        gnt_fire     = (state_q == S_IDLE) && (bus.req0_val || bus.req1_val);
        gnt_id_d     = (bus.req0_val && bus.req1_val) ? rr_ptr_q : bus.req1_val;
        resp_rdy_sel = grant_q ? bus.resp1_rdy : bus.resp0_rdy;
    end

    // rdy is only meaningful in the grant cycle; forced low while in reset
    assign bus.req0_rdy         = reset_n && gnt_fire && !gnt_id_d;
    assign bus.req1_rdy         = reset_n && gnt_fire &&  gnt_id_d;
    assign bus.resp0_val        = (state_q == S_RESP) && !grant_q;
    assign bus.resp1_val        = (state_q == S_RESP) &&  grant_q;
    assign bus.resp_data        = data_q;
    assign bus.cor_operands_val = (state_q == S_ISSUE);
    assign bus.cor_a            = op_a_q;
    assign bus.cor_b            = op_b_q;
    assign bus.busy             = (state_q != S_IDLE);
`ifdef CORDIC_TIMEOUT_EN
    assign bus.resp_err         = err_q;
`else
    assign bus.resp_err         = 1'b0;
`endif

    // Control FSM: grant, issue to datapath, wait for theta, hand result back
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= 1'b0;
            grant_q  <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            data_q   <= '0;
`ifdef CORDIC_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_fire) begin
                        grant_q  <= gnt_id_d;
                        rr_ptr_q <= !gnt_id_d;
                        op_a_q   <= gnt_id_d ? bus.req1_a : bus.req0_a;
                        op_b_q   <= gnt_id_d ? bus.req1_b : bus.req0_b;
                        state_q  <= S_ISSUE;
`ifdef CORDIC_TIMEOUT_EN
                        cnt_q    <= '0;
`endif
                    end
                end
                S_ISSUE: begin
`ifdef CORDIC_TIMEOUT_EN
                    cnt_q <= cnt_q + 1'b1;
`endif
                    if (bus.cor_ready) begin
                        state_q <= S_WAIT;
`ifdef CORDIC_TIMEOUT_EN
                    end else if (cnt_q == CNT_LIM) begin
                        data_q  <= '0;
                        err_q   <= 1'b1;
                        state_q <= S_RESP;
`endif
                    end
                end
                S_WAIT: begin
`ifdef CORDIC_TIMEOUT_EN
                    cnt_q <= cnt_q + 1'b1;
`endif
                    if (bus.cor_out_valid) begin
                        data_q  <= bus.cor_theta;
`ifdef CORDIC_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                        state_q <= S_RESP;
`ifdef CORDIC_TIMEOUT_EN
                    end else if (cnt_q == CNT_LIM) begin
                        data_q  <= '0;
                        err_q   <= 1'b1;
                        state_q <= S_RESP;
`endif
                    end
                end
                S_RESP: begin
                    if (resp_rdy_sel) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_sqrt_arbiter.sv
// tb/tb_cordic_sqrt_arbiter.sv - scoreboard bench for cordic_sqrt_arbiter with a behavioural datapath stub
module tb_cordic_sqrt_arbiter;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    cordic_sqrt_arbiter_if #(.WIDTH(W)) bus ();

    cordic_sqrt_arbiter #(.WIDTH(W), .TIMEOUT(32)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Datapath stub: accepts on val&ready, 16 busy cycles, then one out_valid pulse
    logic         stub_ov    = 1'b0;
    logic         stray_ov   = 1'b0;
    logic         stub_never = 1'b0;
    logic [W-1:0] stub_theta = '0;
    int           stub_cnt   = 0;

    assign bus.cor_out_valid = stub_ov | stray_ov;
    assign bus.cor_theta     = stub_theta;

    always @(posedge clk) begin
        stub_ov <= 1'b0;
        if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1 && !stub_never) stub_ov <= 1'b1;
        end else if (bus.cor_operands_val && bus.cor_ready) begin
            stub_cnt <= 16;
        end
    end

    typedef struct {
        logic         id;
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic idle_inputs();
        bus.req0_val  = 1'b0;
        bus.req0_a    = '0;
        bus.req0_b    = '0;
        bus.req1_val  = 1'b0;
        bus.req1_a    = '0;
        bus.req1_b    = '0;
        bus.resp0_rdy = 1'b1;
        bus.resp1_rdy = 1'b1;
        bus.cor_ready = 1'b1;
    endtask

    task automatic wait_resp(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.resp0_val || bus.resp1_val) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        bus.req0_val = 1'b1;
        repeat (2) @(negedge clk);
        n_run++;
        if ({bus.req0_rdy, bus.req1_rdy, bus.resp0_val, bus.resp1_val, bus.resp_err,
             bus.cor_operands_val, bus.busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000000", {bus.req0_rdy, bus.req1_rdy,
                     bus.resp0_val, bus.resp1_val, bus.resp_err, bus.cor_operands_val, bus.busy});
        end
        n_run++;
        if ({bus.resp_data, bus.cor_a, bus.cor_b} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h/%h want 0", bus.resp_data, bus.cor_a, bus.cor_b);
        end
        bus.req0_val = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        n_run++;
        if (bus.busy !== 1'b0 || bus.req0_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b rdy=%b want 0 0", bus.busy, bus.req0_rdy);
        end
    endtask

    task automatic test_single();
        exp_t e;
        int   first;
        bit   r1seen;
        @(negedge clk);
        bus.req0_val = 1'b1;
        bus.req0_a   = 16'h0400;
        bus.req0_b   = 16'h0100;
        stub_theta   = 16'h0123;
        #1;
        n_run++;
        if ({bus.req0_rdy, bus.req1_rdy} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_grant: rdy0/1=%b want 10", {bus.req0_rdy, bus.req1_rdy});
        end
        sb.push_back('{1'b0, 16'h0123, 1'b0});
        @(negedge clk);
        bus.req0_val = 1'b0;
        n_run++;
        if ({bus.cor_operands_val, bus.busy, bus.req0_rdy} !== 3'b110) begin
            n_fail++;
            $display("FAIL single_issue: val/busy/rdy=%b want 110",
                     {bus.cor_operands_val, bus.busy, bus.req0_rdy});
        end
        n_run++;
        if ({bus.cor_a, bus.cor_b} !== {16'h0400, 16'h0100}) begin
            n_fail++;
            $display("FAIL single_operands: got %h/%h want 0400/0100", bus.cor_a, bus.cor_b);
        end
        first  = 0;
        r1seen = 1'b0;
        for (int c = 2; c <= 30; c++) begin
            @(negedge clk);
            if (bus.resp1_val) r1seen = 1'b1;
            if (bus.resp0_val) begin
                first = c;
                break;
            end
        end
        n_run++;
        if (first !== 19) begin
            n_fail++;
            $display("FAIL single_latency: resp0_val at cycle %0d want 19", first);
        end
        e = sb.pop_front();
        n_run++;
        if ({bus.resp_data, bus.resp_err} !== {e.data, e.err}) begin
            n_fail++;
            $display("FAIL single_data: got %h err %b want %h err %b",
                     bus.resp_data, bus.resp_err, e.data, e.err);
        end
        n_run++;
        if (r1seen || bus.resp1_val !== 1'b0) begin
            n_fail++;
            $display("FAIL single_resp1: resp1_val seen=%b want 0", r1seen | bus.resp1_val);
        end
        @(negedge clk);
        n_run++;
        if (bus.busy !== 1'b0 || bus.resp0_val !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: busy=%b resp0_val=%b want 0 0", bus.busy, bus.resp0_val);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        bit   got;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus.req0_val = 1'b1;
        bus.req0_a   = 16'hA000;
        bus.req0_b   = 16'hA001;
        bus.req1_val = 1'b1;
        bus.req1_a   = 16'hB000;
        bus.req1_b   = 16'hB001;
        for (int r = 0; r < 4; r++) begin
            logic exp_id;
            exp_id = r[0];
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                #1;
                if (bus.req0_rdy || bus.req1_rdy) got = 1'b1;
                else @(negedge clk);
            end
            n_run++;
            if (!got || bus.req1_rdy !== exp_id || bus.req0_rdy !== !exp_id) begin
                n_fail++;
                $display("FAIL rr_grant round %0d: rdy0/1=%b%b want client %0d",
                         r, bus.req0_rdy, bus.req1_rdy, exp_id);
            end
            stub_theta = 16'h1000 + 16'(r);
            sb.push_back('{exp_id, 16'h1000 + 16'(r), 1'b0});
            @(negedge clk);
            n_run++;
            if (bus.cor_a !== (exp_id ? 16'hB000 : 16'hA000)) begin
                n_fail++;
                $display("FAIL rr_operand round %0d: cor_a=%h want %h",
                         r, bus.cor_a, exp_id ? 16'hB000 : 16'hA000);
            end
            wait_resp(40, got);
            e = sb.pop_front();
            n_run++;
            if (!got || bus.resp1_val !== e.id || bus.resp0_val !== !e.id || bus.resp_data !== e.data) begin
                n_fail++;
                $display("FAIL rr_resp round %0d: resp0/1=%b%b data=%h want client %0d data %h",
                         r, bus.resp0_val, bus.resp1_val, bus.resp_data, e.id, e.data);
            end
        end
        bus.req0_val = 1'b0;
        bus.req1_val = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ready_stall();
        exp_t e;
        bit   got;
        int   bad;
        @(negedge clk);
        bus.cor_ready = 1'b0;
        bus.req0_val  = 1'b1;
        bus.req0_a    = 16'h1111;
        bus.req0_b    = 16'h2222;
        stub_theta    = 16'h0777;
        #1;
        sb.push_back('{1'b0, 16'h0777, 1'b0});
        @(negedge clk);
        bus.req0_val = 1'b0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (!(bus.cor_operands_val === 1'b1 && bus.cor_a === 16'h1111 &&
                  bus.cor_b === 16'h2222 && bus.busy === 1'b1)) bad++;
            @(negedge clk);
        end
        bus.cor_ready = 1'b1;
        n_run++;
        if (bad != 0 || bus.cor_operands_val !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_issue: %0d unstable cycles, val=%b want 0 and 1", bad, bus.cor_operands_val);
        end
        @(negedge clk);
        n_run++;
        if (bus.cor_operands_val !== 1'b0 || bus.busy !== 1'b1 || bus.cor_a !== 16'h1111) begin
            n_fail++;
            $display("FAIL stall_to_wait: val=%b busy=%b a=%h want 0 1 1111",
                     bus.cor_operands_val, bus.busy, bus.cor_a);
        end
        wait_resp(40, got);
        e = sb.pop_front();
        n_run++;
        if (!got || bus.resp0_val !== 1'b1 || bus.resp_data !== e.data) begin
            n_fail++;
            $display("FAIL stall_resp: resp0_val=%b data=%h want 1 %h", bus.resp0_val, bus.resp_data, e.data);
        end
        @(negedge clk);
    endtask

    task automatic test_resp_stall();
        exp_t e;
        bit   got;
        int   bad;
        @(negedge clk);
        bus.resp0_rdy = 1'b0;
        bus.req0_val  = 1'b1;
        bus.req0_a    = 16'h3333;
        bus.req0_b    = 16'h4444;
        stub_theta    = 16'h0ABC;
        #1;
        sb.push_back('{1'b0, 16'h0ABC, 1'b0});
        @(negedge clk);
        bus.req0_val = 1'b0;
        bus.req1_val = 1'b1;
        bus.req1_a   = 16'h5555;
        bus.req1_b   = 16'h6666;
        wait_resp(40, got);
        e = sb.pop_front();
        n_run++;
        if (!got || bus.resp0_val !== 1'b1 || bus.resp_data !== e.data) begin
            n_fail++;
            $display("FAIL hold_first: resp0_val=%b data=%h want 1 %h", bus.resp0_val, bus.resp_data, e.data);
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.resp0_val !== 1'b1 || bus.resp_data !== e.data ||
                bus.req1_rdy !== 1'b0 || bus.resp1_val !== 1'b0) bad++;
        end
        n_run++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_stable: %0d bad cycles want 0", bad);
        end
        bus.resp0_rdy = 1'b1;
        @(negedge clk);
        #1;
        n_run++;
        if (bus.req1_rdy !== 1'b1 || bus.resp0_val !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_handoff: req1_rdy=%b resp0_val=%b want 1 0", bus.req1_rdy, bus.resp0_val);
        end
        stub_theta = 16'h0DEF;
        sb.push_back('{1'b1, 16'h0DEF, 1'b0});
        @(negedge clk);
        bus.req1_val = 1'b0;
        n_run++;
        if (bus.cor_a !== 16'h5555 || bus.cor_b !== 16'h6666) begin
            n_fail++;
            $display("FAIL hold_operands1: got %h/%h want 5555/6666", bus.cor_a, bus.cor_b);
        end
        wait_resp(40, got);
        e = sb.pop_front();
        n_run++;
        if (!got || bus.resp1_val !== 1'b1 || bus.resp0_val !== 1'b0 || bus.resp_data !== e.data) begin
            n_fail++;
            $display("FAIL hold_second: resp0/1=%b%b data=%h want 01 %h",
                     bus.resp0_val, bus.resp1_val, bus.resp_data, e.data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int bad;
        @(negedge clk);
        bus.req0_val = 1'b1;
        bus.req0_a   = 16'h7777;
        bus.req0_b   = 16'h8888;
        stub_theta   = 16'h0555;
        sb.push_back('{1'b0, 16'h0555, 1'b0});
        @(negedge clk);
        bus.req0_val = 1'b0;
        repeat (4) @(negedge clk);
        n_run++;
        if (bus.busy !== 1'b1 || bus.cor_operands_val !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_wait: busy=%b val=%b want 1 0", bus.busy, bus.cor_operands_val);
        end
        reset_n = 1'b0;
        @(negedge clk);
        sb.delete();
        n_run++;
        if ({bus.busy, bus.resp0_val, bus.resp1_val, bus.cor_operands_val, bus.resp_err} !== 5'b0 ||
            {bus.resp_data, bus.cor_a, bus.cor_b} !== 48'h0) begin
            n_fail++;
            $display("FAIL midrst_outputs: ctrl=%b a=%h b=%h data=%h want all 0",
                     {bus.busy, bus.resp0_val, bus.resp1_val, bus.cor_operands_val, bus.resp_err},
                     bus.cor_a, bus.cor_b, bus.resp_data);
        end
        reset_n  = 1'b1;
        stray_ov = 1'b1;
        @(negedge clk);
        stray_ov = 1'b0;
        bad = 0;
        for (int c = 0; c < 25; c++) begin
            if (bus.resp0_val || bus.resp1_val || bus.busy !== 1'b0) bad++;
            @(negedge clk);
        end
        n_run++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL midrst_stray: %0d cycles with resp/busy want 0", bad);
        end
    endtask

`ifdef CORDIC_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        int   first;
        @(negedge clk);
        stub_never   = 1'b1;
        bus.req1_val = 1'b1;
        bus.req1_a   = 16'h0F0F;
        bus.req1_b   = 16'h00F0;
        stub_theta   = 16'hBEEF;
        #1;
        n_run++;
        if (bus.req1_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_grant: req1_rdy=%b want 1", bus.req1_rdy);
        end
        sb.push_back('{1'b1, 16'h0000, 1'b1});
        @(negedge clk);
        bus.req1_val = 1'b0;
        first = 0;
        for (int c = 1; c <= 45; c++) begin
            if (bus.resp0_val || bus.resp1_val) begin
                first = c;
                break;
            end
            @(negedge clk);
        end
        n_run++;
        if (first !== 33) begin
            n_fail++;
            $display("FAIL timeout_latency: resp at cycle %0d want 33", first);
        end
        e = sb.pop_front();
        n_run++;
        if (bus.resp1_val !== e.id || bus.resp_data !== e.data || bus.resp_err !== e.err) begin
            n_fail++;
            $display("FAIL timeout_resp: resp1=%b data=%h err=%b want 1 %h %b",
                     bus.resp1_val, bus.resp_data, bus.resp_err, e.data, e.err);
        end
        @(negedge clk);
        stub_never = 1'b0;
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_ready_stall();
        test_resp_stall();
        test_reset_mid();
`ifdef CORDIC_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
